// File: rtl/max_pooling_layer_pkg.sv
// Shared helpers for the pooling stage: counter width sizing and signed max.
package max_pooling_layer_pkg;

  // Widest channel value the signed_max helper can handle
  localparam int MAX_W = 64;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Signed maximum; ties return the first operand, which is equally valid
  function automatic logic signed [MAX_W-1:0] signed_max(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pooling_layer_if.sv
// Pixel stream bundle between the upstream layer (master) and the pooling stage (slave).
interface max_pooling_layer_if #(
  parameter int DATA_W = 80
);
  logic              clk_en;
  logic [DATA_W-1:0] input_data;
  logic [DATA_W-1:0] output_data;
  logic              valid;
  logic              frame_done;

  modport master (
    output clk_en, input_data,
    input  output_data, valid, frame_done
  );

  modport slave (
    input  clk_en, input_data,
    output output_data, valid, frame_done
  );
endinterface

// File: rtl/max_pooling_layer_channel_max.sv
// Combinational per-channel signed maximum of two packed multi-channel pixels.
module channel_max
  import max_pooling_layer_pkg::*;
#(
  parameter int I_WIDTH  = 16,
  parameter int CHANNELS = 5
) (
  input  logic [CHANNELS*I_WIDTH-1:0] a,
  input  logic [CHANNELS*I_WIDTH-1:0] b,
  output logic [CHANNELS*I_WIDTH-1:0] y
);

  if (I_WIDTH > MAX_W) begin : g_bad_width
    $error("channel_max: I_WIDTH exceeds the signed_max operand width");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [I_WIDTH-1:0] a_ch;
    logic signed [I_WIDTH-1:0] b_ch;
    logic signed [MAX_W-1:0]   m_ch;

    assign a_ch = a[c*I_WIDTH +: I_WIDTH];
    assign b_ch = b[c*I_WIDTH +: I_WIDTH];
    assign m_ch = signed_max(MAX_W'(a_ch), MAX_W'(b_ch));
    assign y[c*I_WIDTH +: I_WIDTH] = m_ch[I_WIDTH-1:0];
  end

endmodule

// File: rtl/max_pooling_layer.sv
// Streaming 2x2 stride-2 max pooling with a half-row line buffer of partial maxima.
module max_pooling_layer
  import max_pooling_layer_pkg::*;
#(
  parameter int I_WIDTH    = 16,
  parameter int CHANNELS   = 5,
  parameter int IMAGE_SIZE = 254
) (
  input logic                 clk,
  input logic                 rst_n,
  max_pooling_layer_if.slave  bus
);

  localparam int DATA_W = CHANNELS * I_WIDTH;
  localparam int HALF   = IMAGE_SIZE / 2;
  localparam int COL_W  = cnt_width(IMAGE_SIZE);
  localparam int ROW_W  = cnt_width(IMAGE_SIZE);
  localparam int LB_W   = cnt_width(HALF);

  typedef logic [DATA_W-1:0] pixel_t;

  if (IMAGE_SIZE % 2 != 0) begin : g_odd_size
    $error("max_pooling_layer: IMAGE_SIZE must be even");
  end

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;
  logic [LB_W-1:0]  lbuf_idx;

  pixel_t h_max;
  pixel_t pair_max;
  pixel_t vert_max;
  pixel_t lbuf_rd;
  pixel_t output_data_q;
  logic   valid_q;
  logic   frame_done_q;

  pixel_t lbuf [HALF];

  assign col_last = (col == COL_W'(IMAGE_SIZE - 1));
  assign row_last = (row == ROW_W'(IMAGE_SIZE - 1));
  assign lbuf_idx = LB_W'(col >> 1);
  assign lbuf_rd  = lbuf[lbuf_idx];

  // Horizontal max of the held even-column pixel and the current odd-column pixel
  channel_max #(.I_WIDTH(I_WIDTH), .CHANNELS(CHANNELS)) u_pair_max (
    .a (h_max),
    .b (bus.input_data),
    .y (pair_max)
  );

  // Vertical max of the upper-row partial and the current lower-row pair
  channel_max #(.I_WIDTH(I_WIDTH), .CHANNELS(CHANNELS)) u_vert_max (
    .a (lbuf_rd),
    .b (pair_max),
    .y (vert_max)
  );

  // Upper-row pair maxima are parked here until the lower row of the window arrives
  always_ff @(posedge clk) begin
    if (bus.clk_en && col[0] && !row[0]) begin
      lbuf[lbuf_idx] <= pair_max;
    end
  end

  // Raster counters, even-column hold register and registered pooled output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      h_max         <= '0;
      output_data_q <= '0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.clk_en) begin
        if (!col[0]) begin
          h_max <= bus.input_data;
        end else if (row[0]) begin
          output_data_q <= vert_max;
          valid_q       <= 1'b1;
          frame_done_q  <= col_last && row_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign bus.output_data = output_data_q;
  assign bus.valid       = valid_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_max_pooling_layer.sv
// Scoreboard bench for max_pooling_layer: a 4x4 two-channel instance for directed
// frames and a 254x254 five-channel instance for a random frame against a full-frame model.
module tb_max_pooling_layer;

  localparam int SW     = 16;
  localparam int S_CH   = 2;
  localparam int S_SIZE = 4;
  localparam int B_CH   = 5;
  localparam int B_SIZE = 254;
  localparam int B_HALF = B_SIZE / 2;

  typedef struct {
    logic [79:0] data;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t sb_small[$];
  exp_t sb_big[$];

  logic [79:0] big_frame [B_SIZE*B_SIZE];

  logic signed [15:0] ramp_ch0 [4] = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
  logic signed [15:0] ramp_ch1 [4] = '{16'sd0, -16'sd2, -16'sd8, -16'sd10};
  logic signed [15:0] sgn_ch0  [4] = '{-16'sd3, -16'sd1, -16'sd7, -16'sd2};
  logic signed [15:0] sgn_ch1  [4] = '{-16'sd3, 16'sd2, -16'sd7, 16'sd1};

  max_pooling_layer_if #(.DATA_W(S_CH*SW)) bus_small ();
  max_pooling_layer_if #(.DATA_W(B_CH*SW)) bus_big ();

  max_pooling_layer #(.I_WIDTH(SW), .CHANNELS(S_CH), .IMAGE_SIZE(S_SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_small)
  );

  max_pooling_layer #(.I_WIDTH(SW), .CHANNELS(B_CH), .IMAGE_SIZE(B_SIZE)) dut_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_big)
  );

  // Free-running clock and cycle counter used for latency checks
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check_output(input string name, input logic [79:0] actual, input logic [79:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic logic [31:0] make_pixel(input int kind, input int r, input int c, input int offset);
    logic signed [15:0] ch0;
    logic signed [15:0] ch1;
    int v;
    int k;
    v = r * 4 + c;
    k = (r % 2) * 2 + (c % 2);
    if (kind == 0) begin
      ch0 = 16'(v + offset);
      ch1 = 16'(offset - v);
    end else begin
      ch0 = sgn_ch0[k];
      ch1 = sgn_ch1[k];
    end
    return {ch1, ch0};
  endfunction

  function automatic logic [79:0] expected_small(input int kind, input int w, input int offset);
    logic [15:0] e0;
    logic [15:0] e1;
    if (kind == 0) begin
      e0 = 16'(ramp_ch0[w] + 16'(offset));
      e1 = 16'(ramp_ch1[w] + 16'(offset));
    end else begin
      e0 = 16'hFFFF;
      e1 = 16'd2;
    end
    return {48'd0, e1, e0};
  endfunction

  task automatic apply_stimulus(input logic [31:0] px);
    @(posedge clk);
    #1;
    bus_small.clk_en     = 1'b1;
    bus_small.input_data = px;
  endtask

  task automatic apply_idle();
    @(posedge clk);
    #1;
    bus_small.clk_en     = 1'b0;
    bus_small.input_data = $urandom;
    bus_big.clk_en       = 1'b0;
  endtask

  // Drives the first n pixels of a 4x4 frame and queues the pooled result of each completed window
  task automatic apply_frame(input int kind, input int offset, input bit gap, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r = i / 4;
      c = i % 4;
      apply_stimulus(make_pixel(kind, r, c, offset));
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.data = expected_small(kind, (r / 2) * 2 + (c / 2), offset);
        e.done = (r == 3) && (c == 3);
        e.cyc  = cyc + 1;
        sb_small.push_back(e);
      end
      if (gap) apply_idle();
    end
  endtask

  function automatic logic signed [15:0] big_ch(input int r, input int c, input int ch);
    logic [79:0] p;
    p = big_frame[r * B_SIZE + c];
    return p[ch*16 +: 16];
  endfunction

  // Small-instance monitor: pops the scoreboard on every valid pulse
  initial begin
    forever begin
      @(negedge clk);
      if (bus_small.valid) begin
        if (sb_small.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL small unexpected valid: actual=1 required=0 data=%0h", bus_small.output_data);
        end else begin
          exp_t e;
          e = sb_small.pop_front();
          check_output("small data", {48'd0, bus_small.output_data}, e.data);
          check_output("small frame_done", {79'd0, bus_small.frame_done}, {79'd0, e.done});
          check_output("small latency cycle", 80'(cyc), 80'(e.cyc));
        end
      end else begin
        check_output("small stray frame_done", {79'd0, bus_small.frame_done}, 80'd0);
      end
    end
  end

  // Large-instance monitor: pops the scoreboard on every valid pulse
  initial begin
    forever begin
      @(negedge clk);
      if (bus_big.valid) begin
        if (sb_big.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL big unexpected valid: actual=1 required=0 data=%0h", bus_big.output_data);
        end else begin
          exp_t e;
          e = sb_big.pop_front();
          check_output("big data", bus_big.output_data, e.data);
          check_output("big frame_done", {79'd0, bus_big.frame_done}, {79'd0, e.done});
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_small.clk_en     = 1'b0;
    bus_small.input_data = '0;
    bus_big.clk_en       = 1'b0;
    bus_big.input_data   = '0;

    repeat (2) @(negedge clk);
    check_output("reset output_data", {48'd0, bus_small.output_data}, 80'd0);
    check_output("reset valid", {79'd0, bus_small.valid}, 80'd0);
    check_output("reset frame_done", {79'd0, bus_small.frame_done}, 80'd0);
    check_output("reset big output_data", bus_big.output_data, 80'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] ramp frame, continuous enable");
    apply_frame(0, 0, 1'b0, 16);
    apply_idle();

    $display("[TB] ramp frame, toggling enable");
    apply_frame(0, 0, 1'b1, 16);
    apply_idle();

    $display("[TB] signed window frame");
    apply_frame(1, 0, 1'b0, 16);
    apply_idle();

    $display("[TB] two frames back to back");
    apply_frame(0, 0, 1'b0, 16);
    apply_frame(0, 100, 1'b0, 16);
    repeat (3) apply_idle();

    $display("[TB] reset mid-frame");
    apply_frame(0, 0, 1'b0, 6);
    repeat (3) apply_idle();
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_output("mid reset output_data", {48'd0, bus_small.output_data}, 80'd0);
      check_output("mid reset valid", {79'd0, bus_small.valid}, 80'd0);
      check_output("mid reset frame_done", {79'd0, bus_small.frame_done}, 80'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_frame(0, 0, 1'b0, 16);
    repeat (3) apply_idle();

    $display("[TB] 254x254 random frame");
    for (int i = 0; i < B_SIZE * B_SIZE; i++) begin
      logic [95:0] tmp;
      tmp = {$urandom, $urandom, $urandom};
      big_frame[i] = tmp[79:0];
    end
    for (int wr = 0; wr < B_HALF; wr++) begin
      for (int wc = 0; wc < B_HALF; wc++) begin
        exp_t e;
        e.data = '0;
        for (int ch = 0; ch < B_CH; ch++) begin
          logic signed [15:0] m;
          m = big_ch(2 * wr, 2 * wc, ch);
          for (int d = 1; d < 4; d++) begin
            logic signed [15:0] v;
            v = big_ch(2 * wr + d / 2, 2 * wc + d % 2, ch);
            if (v > m) m = v;
          end
          e.data[ch*16 +: 16] = m;
        end
        e.done = (wr == B_HALF - 1) && (wc == B_HALF - 1);
        e.cyc  = 0;
        sb_big.push_back(e);
      end
    end
    for (int i = 0; i < B_SIZE * B_SIZE; i++) begin
      @(posedge clk);
      #1;
      bus_big.clk_en     = 1'b1;
      bus_big.input_data = big_frame[i];
    end
    repeat (4) apply_idle();

    check_output("small scoreboard drained", 80'(sb_small.size()), 80'd0);
    check_output("big scoreboard drained", 80'(sb_big.size()), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
